// File: rtl/tia_player_pkg.sv
// Shared encodings and helpers for the player graphics scan counter.
package tia_player_pkg;

  localparam logic [1:0] SIZE_1X = 2'b00;
  localparam logic [1:0] SIZE_2X = 2'b01;
  localparam logic [1:0] SIZE_4X = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  // Last stretch count of a bit; the reserved code 2'b10 draws as 1x.
  function automatic logic [1:0] stretch_limit(input logic [1:0] size);
    case (size)
      SIZE_2X: stretch_limit = 2'd1;
      SIZE_4X: stretch_limit = 2'd3;
      default: stretch_limit = 2'd0;
    endcase
  endfunction

  function automatic logic is_wide(input logic [1:0] size);
    is_wide = (size == SIZE_2X) || (size == SIZE_4X);
  endfunction

endpackage

// File: rtl/tia_player_scan_counter_stretch_prescaler.sv
// Stretch counter: holds each graphics bit for 1, 2 or 4 enabled pixel cycles.
module tia_player_stretch_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       clear,
  input  logic [1:0] limit,
  output logic       bit_advance
);

  logic [1:0] cnt;

  // High during the final enabled cycle of the current bit.
  assign bit_advance = (cnt == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (pix_en) begin
      if (clear || bit_advance) cnt <= 2'd0;
      else                      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/tia_player_scan_counter.sv
// Player scan counter: start pulse -> gs0..gs2 graphics select and active window.
// Optional macro TIA_PLAYER_WIDE_DELAY_EN adds one delay pixel for 2x/4x players.
module tia_player_scan_counter
  import tia_player_pkg::*;
#(
  parameter int PIX_DELAY = 1  // legal range 1..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       start,
  input  logic [1:0] size,
  input  logic       reflect,
  output logic       gs0,
  output logic       gs1,
  output logic       gs2,
  output logic       active,
  output logic       done
);

  logic [1:0] state;
  logic [1:0] size_q;
  logic [1:0] dly_cnt;
  logic [2:0] idx;
  logic [2:0] gs_q;
  logic [2:0] dly_total;
  logic       scan;
  logic       bit_adv;
  logic       last_pix;

  function automatic logic [2:0] gs_of(input logic [2:0] bit_idx, input logic refl);
    gs_of = refl ? bit_idx : (3'd7 - bit_idx);
  endfunction

  always_comb begin
    dly_total = 3'(PIX_DELAY);
`ifdef TIA_PLAYER_WIDE_DELAY_EN
    if (is_wide(size)) dly_total = dly_total + 3'd1;
`else
    dly_total = dly_total + 3'd0;
`endif
  end

  assign scan     = (state == ST_SCAN);
  assign last_pix = scan && bit_adv && (idx == 3'd7);

  // A restart on the final pixel suppresses the completion strobe.
  assign done   = !reset && pix_en && last_pix && !start;
  assign active = scan;
  assign gs0    = gs_q[0];
  assign gs1    = gs_q[1];
  assign gs2    = gs_q[2];

  tia_player_stretch_prescaler u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .clear       (!scan || start),
    .limit       (stretch_limit(size_q)),
    .bit_advance (bit_adv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      size_q  <= SIZE_1X;
      dly_cnt <= 2'd0;
      idx     <= 3'd0;
      gs_q    <= 3'd0;
    end else if (pix_en) begin
      if (start) begin
        size_q <= size;
        idx    <= 3'd0;
        if (dly_total == 3'd1) begin
          state   <= ST_SCAN;
          dly_cnt <= 2'd0;
          gs_q    <= gs_of(3'd0, reflect);
        end else begin
          state   <= ST_DELAY;
          dly_cnt <= 2'(dly_total - 3'd1);
        end
      end else begin
        case (state)
          ST_DELAY: begin
            dly_cnt <= dly_cnt - 2'd1;
            if (dly_cnt <= 2'd1) begin
              state <= ST_SCAN;
              idx   <= 3'd0;
              gs_q  <= gs_of(3'd0, reflect);
            end
          end
          ST_SCAN: begin
            if (bit_adv) begin
              // gs holds the last bit's select after the scan ends.
              if (idx == 3'd7) begin
                state <= ST_IDLE;
              end else begin
                idx  <= idx + 3'd1;
                gs_q <= gs_of(idx + 3'd1, reflect);
              end
            end
          end
          ST_IDLE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
